// File: rtl/wait_pulse_gen.sv
// wait_pulse_gen
// Detects when a metered vehicle has stopped and charges waiting time.
// A 1 s tick comes from a free-running prescaler. After STOP_TICKS ticks with
// no wheel edge, the vehicle counts as waiting. While waiting, every tick adds
// one second to an MM:SS BCD total. Every UNIT_SEC waiting ticks issue one
// wait-fare pulse, unless the fare is already at its ceiling.
//
// Ports
//   clk             system clock, rising edge
//   rst             synchronous active-high reset
//   wheel_pulse     wheel sensor level (already synchronous to clk)
//   trip_active     meter running; 0 returns to IDLE
//   max             fare at ceiling; suppresses wait charging
//   wait_en         registered: next state is WAITING and max is low
//   wait_fare_pulse one-clk pulse per completed wait unit
//   wait_time_bcd   waiting time this trip, BCD MM:SS, saturates at 99:59
//
// state   | meaning
// IDLE    | no trip; outputs hold, wait_en low
// MOVING  | trip running, wheel turning; counting ticks without wheel edges
// WAITING | vehicle stopped; ticks add waiting time and charge units
module wait_pulse_gen #(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned STOP_TICKS = 3,
  parameter int unsigned UNIT_SEC   = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wheel_pulse,
  input  logic        trip_active,
  input  logic        max,
  output logic        wait_en,
  output logic        wait_fare_pulse,
  output logic [15:0] wait_time_bcd
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(STOP_TICKS + 1);
  localparam int UW = (UNIT_SEC > 1) ? $clog2(UNIT_SEC) : 1;

  typedef enum logic [1:0] {IDLE, MOVING, WAITING} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q;
  logic [SW-1:0]   stop_q, stop_d;
  logic [UW-1:0]   unit_q, unit_d;
  logic [15:0]     bcd_d;
  logic            pulse_d;
  logic            wheel_d;
  logic            tick;
  logic            wheel_edge;

  // One-second increment of an MM:SS BCD value. It holds at 99:59.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [3:0] s0, s1, m0, m1;
    {m1, m0, s1, s0} = v;
    if (v != 16'h9959) begin
      if (s0 != 4'd9) begin
        s0 = s0 + 4'd1;
      end else begin
        s0 = 4'd0;
        if (s1 != 4'd5) begin
          s1 = s1 + 4'd1;
        end else begin
          s1 = 4'd0;
          if (m0 != 4'd9) begin
            m0 = m0 + 4'd1;
          end else begin
            m0 = 4'd0;
            m1 = m1 + 4'd1;
          end
        end
      end
    end
    bcd_inc = {m1, m0, s1, s0};
  endfunction

  assign tick       = (presc_q == PW'(TICK_DIV - 1));
  assign wheel_edge = wheel_pulse & ~wheel_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    stop_d  = stop_q;
    unit_d  = unit_q;
    bcd_d   = wait_time_bcd;
    pulse_d = 1'b0;
    if (!trip_active) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = MOVING;
          stop_d  = '0;
          unit_d  = '0;
          bcd_d   = 16'h0000;
        end
        MOVING: begin
          if (wheel_edge) begin
            stop_d = '0;
          end else if (tick) begin
            stop_d = stop_q + SW'(1);
            if (stop_q == SW'(STOP_TICKS - 1)) state_d = WAITING;
          end
        end
        WAITING: begin
          // A wheel edge ends waiting. A tick in the same cycle is dropped.
          if (wheel_edge) begin
            state_d = MOVING;
            stop_d  = '0;
          end else if (tick) begin
            bcd_d = bcd_inc(wait_time_bcd);
            if (unit_q == UW'(UNIT_SEC - 1)) begin
              unit_d  = '0;
              pulse_d = !max;
            end else begin
              unit_d = unit_q + UW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      stop_q          <= '0;
      unit_q          <= '0;
      wheel_d         <= 1'b0;
      wait_en         <= 1'b0;
      wait_fare_pulse <= 1'b0;
      wait_time_bcd   <= 16'h0000;
    end else begin
      state_q         <= state_d;
      stop_q          <= stop_d;
      unit_q          <= unit_d;
      wheel_d         <= wheel_pulse;
      wait_en         <= (state_d == WAITING) && !max;
      wait_fare_pulse <= pulse_d;
      wait_time_bcd   <= bcd_d;
    end
  end

endmodule

// File: doc/wait_pulse_gen.md
WAIT_PULSE_GEN -- requirements
Module: wait_pulse_gen

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50_000_000, clk cycles per 1 s tick.
REQ-002 SHALL have parameter STOP_TICKS, default 3, ticks without a wheel edge before the vehicle is declared stopped.
REQ-003 SHALL have parameter UNIT_SEC, default 60, waiting ticks per wait_fare_pulse.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port wheel_pulse  input  1  wheel sensor level, already synchronous to clk.
REQ-007 SHALL have port trip_active  input  1  meter running; 0 = no trip.
REQ-008 SHALL have port max  input  1  fare at ceiling; suppresses wait charging.
REQ-009 SHALL have port wait_en  output  1  wait-fare accumulation enable for the downstream wait_fare block.
REQ-010 SHALL have port wait_fare_pulse  output  1  one-clk pulse per completed wait unit.
REQ-011 SHALL have port wait_time_bcd  output  16  total waiting time this trip, BCD MM:SS as [15:12][11:8][7:4][3:0].

Function
REQ-012 SHALL run a free-running prescaler 0..TICK_DIV-1; tick is high for one clk when it equals TICK_DIV-1; only rst clears it.
REQ-013 SHALL detect wheel edge = wheel_pulse & ~wheel_pulse_d, where wheel_pulse_d is a register.
REQ-014 SHALL implement states IDLE, MOVING, WAITING; all outputs registered.
REQ-015 IDLE->MOVING SHALL occur when trip_active=1; this entry clears stop_cnt, unit_cnt and wait_time_bcd.
REQ-016 In MOVING, a wheel edge SHALL clear stop_cnt; otherwise each tick SHALL increment stop_cnt; wheel edge wins over a simultaneous tick.
REQ-017 MOVING->WAITING SHALL occur on the tick that makes stop_cnt reach STOP_TICKS.
REQ-018 WAITING->MOVING SHALL occur on a wheel edge, which also clears stop_cnt; a tick in the same cycle is not counted.
REQ-019 Any state ->IDLE SHALL occur when trip_active=0; this takes priority over all other events, and no pulse is generated in that cycle.
REQ-020 In WAITING, each tick SHALL increment wait_time_bcd (SS 00-59 rolls into MM) and unit_cnt.
REQ-021 wait_time_bcd SHALL saturate at 16'h9959 and hold.
REQ-022 wait_time_bcd SHALL hold its value in IDLE and MOVING.
REQ-023 When a WAITING tick finds unit_cnt=UNIT_SEC-1 and max=0, unit_cnt SHALL clear and wait_fare_pulse SHALL be 1 for exactly the next clk.
REQ-024 When max=1 at that tick, unit_cnt SHALL clear and no pulse SHALL be issued.
REQ-025 unit_cnt SHALL be retained across WAITING->MOVING->WAITING, so a partial unit carries over within a trip.
REQ-026 wait_en SHALL equal registered (next_state==WAITING && !max), so it rises in the same clk the state becomes WAITING.
REQ-027 wait_fare_pulse SHALL never be high for two consecutive clks when TICK_DIV>=2.

Reset
REQ-028 While rst=1 at a clk edge, the block SHALL go to IDLE and clear the prescaler, stop_cnt, unit_cnt and wheel_pulse_d.
REQ-029 While rst=1, it SHALL drive wait_en=0, wait_fare_pulse=0 and wait_time_bcd=16'h0000.
REQ-030 Reset mid-trip SHALL discard the partial unit; once rst=0 and trip_active=1, the block SHALL re-enter MOVING.

Verification (TICK_DIV=4, STOP_TICKS=2, UNIT_SEC=3)
REQ-031 Bench SHALL cover: rst=1 for 3 clks during WAITING -> all outputs 0 on the next edge; IDLE after release with trip_active=0.
REQ-032 Bench SHALL cover: trip_active=1, wheel edge every tick for 20 ticks -> wait_en=0, no pulses, wait_time_bcd=0000.
REQ-033 Bench SHALL cover: wheel stops -> wait_en=1 after 2 ticks; 9 further ticks -> exactly 3 one-clk pulses, each 12 clks apart; wait_time_bcd=0009.
REQ-034 Bench SHALL cover: max=1 for 6 waiting ticks -> wait_en=0, no pulses, time +6; max=0 -> wait_en=1, next pulse after 3 ticks.
REQ-035 Bench SHALL cover: wheel edge with unit_cnt=2, then stop again -> first pulse on the 1st waiting tick after re-entering WAITING.
REQ-036 Bench SHALL cover: TICK_DIV=1, wait 6000 ticks -> wait_time_bcd=9959 held; trip_active=0 -> IDLE, value held; trip_active=1 -> cleared to 0000.
